// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg -- shared types for the multi-cycle shift/rotate controller.
//
// Contents:
//   op_e          operation encoding driven on shift_ctrl.op
//   state_e       controller FSM states
//   is_legal_op() true for the five defined operations
// -----------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [2:0] {
        OP_ROR  = 3'b000,
        OP_ROL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_SHRA = 3'b011,
        OP_SHL  = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [2:0] code);
        return code <= 3'b100;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage -- one combinational stage of the log-shifter. When enabled it
// moves the data by 2^i_stage positions in the direction of i_op; otherwise it
// passes the data through unchanged.
//
// Ports:
//   i_data   [DATA_WIDTH-1:0]  data entering the stage
//   i_op     op_e              operation (illegal codes pass through)
//   i_stage  [SH_W-1:0]        stage index, move distance = 2^i_stage
//   i_en                       amount bit for this stage
//   i_sign                     operand sign bit used as SHRA fill
//   o_data   [DATA_WIDTH-1:0]  stepped data
// -----------------------------------------------------------------------------
module shift_stage
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SH_W       = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  op_e                   i_op,
    input  logic [SH_W-1:0]       i_stage,
    input  logic                  i_en,
    input  logic                  i_sign,
    output logic [DATA_WIDTH-1:0] o_data
);

    // One extra bit so DATA_WIDTH itself is representable.
    logic [SH_W:0]           w_dist;
    logic [SH_W:0]           w_inv;
    logic [DATA_WIDTH-1:0]   w_shr;
    logic [DATA_WIDTH-1:0]   w_shl;

    assign w_dist = {{SH_W{1'b0}}, 1'b1} << i_stage;
    // i_stage <= SH_W-1, so w_inv is never zero and never DATA_WIDTH.
    assign w_inv  = (SH_W + 1)'(DATA_WIDTH) - w_dist;
    assign w_shr  = i_data >> w_dist;
    assign w_shl  = i_data << w_dist;

    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                OP_ROR:  o_data = w_shr | (i_data << w_inv);
                OP_ROL:  o_data = w_shl | (i_data >> w_inv);
                OP_SHR:  o_data = w_shr;
                OP_SHRA: o_data = w_shr | ({DATA_WIDTH{i_sign}} << w_inv);
                OP_SHL:  o_data = w_shl;
                default: o_data = i_data;
            endcase
        end
    end

endmodule

// File: rtl/shift_ctrl.sv
// -----------------------------------------------------------------------------
// shift_ctrl -- multi-cycle rotate/shift unit with valid/ready handshakes.
// One shift_stage is applied per SHIFT cycle (log-shifter unrolled in time).
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   start_valid / start_ready  operation handshake (ready only in IDLE)
//   op [2:0]                   ROR/ROL/SHR/SHRA/SHL; 101-111 behave as amount 0
//   A, B [DATA_WIDTH-1:0]      operand and amount (only B[SH_W-1:0] used)
//   result_valid/result_ready  result handshake; Z held while waiting
//   Z [DATA_WIDTH-1:0]         result
//   busy                       high whenever not IDLE
//
// Build option: SHIFT_CTRL_SKIP_ZERO_EN -- step only over the set amount bits,
// giving latency 1 + max(1, popcount(amount)) instead of SH_W + 1. Results are
// identical in both builds.
// -----------------------------------------------------------------------------
module shift_ctrl
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [DATA_WIDTH-1:0] Z,
    output logic                  busy
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    state_e                r_state;
    logic [SH_W-1:0]       r_step;
    logic [SH_W-1:0]       r_amt;
    logic [DATA_WIDTH-1:0] r_data;
    op_e                   r_op;
    logic                  r_sign;
    logic                  r_start_ready;
    logic                  r_busy;
    logic                  r_result_valid;

    logic [SH_W-1:0]       w_amt_in;
    logic [SH_W-1:0]       w_amt_at_step;
    logic [DATA_WIDTH-1:0] w_stepped;
    logic [SH_W-1:0]       w_first_step;
    logic [SH_W-1:0]       w_next_step;
    logic                  w_last;
    logic                  w_unused_b;

    // Illegal ops are captured with amount 0 so every stage passes A through.
    assign w_amt_in      = is_legal_op(op) ? B[SH_W-1:0] : '0;
    assign w_amt_at_step = r_amt >> r_step;
    assign w_unused_b    = ^B[DATA_WIDTH-1:SH_W];

    shift_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .SH_W       (SH_W)
    ) u_stage (
        .i_data  (r_data),
        .i_op    (r_op),
        .i_stage (r_step),
        .i_en    (w_amt_at_step[0]),
        .i_sign  (r_sign),
        .o_data  (w_stepped)
    );

`ifdef SHIFT_CTRL_SKIP_ZERO_EN
    // Step sequencing visits only the set amount bits, lowest first. Amount 0
    // still spends one SHIFT cycle (a pass-through at stage 0).
    logic w_has_next;

    always_comb begin
        w_first_step = '0;
        w_next_step  = '0;
        w_has_next   = 1'b0;
        for (int i = SH_W - 1; i >= 0; i--) begin
            if (w_amt_in[i]) w_first_step = SH_W'(i);
            if (r_amt[i] && (i > int'(r_step))) begin
                w_next_step = SH_W'(i);
                w_has_next  = 1'b1;
            end
        end
        w_last = !w_has_next;
    end
`else
    // Fixed schedule: every stage is visited, enabled or not.
    assign w_first_step = '0;
    assign w_next_step  = r_step + 1'b1;
    assign w_last       = (r_step == SH_W'(SH_W - 1));
`endif

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_step         <= '0;
            r_amt          <= '0;
            r_data         <= '0;
            r_op           <= OP_ROR;
            r_sign         <= 1'b0;
            r_start_ready  <= 1'b1;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_data        <= A;
                        r_amt         <= w_amt_in;
                        r_op          <= op_e'(op);
                        r_sign        <= A[DATA_WIDTH-1];
                        r_step        <= w_first_step;
                        r_state       <= S_SHIFT;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_data <= w_stepped;
                    r_step <= w_next_step;
                    if (w_last) begin
                        r_state        <= S_DONE;
                        r_result_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        r_state        <= S_IDLE;
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_start_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_result_valid <= 1'b0;
                    r_busy         <= 1'b0;
                    r_start_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign start_ready  = r_start_ready;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign Z            = r_data;

endmodule
